// File: rtl/tt_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tt_mux_pkg
//  Brief   : Shared widths, field offsets and slot-FSM state encoding for the
//            multi-project TT pin mux.
//  Revision: 1.0 - initial release
// ============================================================================
package tt_mux_pkg;

    // Flat per-slot packing widths
    localparam int TT_IW_W = 18;
    localparam int TT_OW_W = 24;

    // proj_iw field offsets: {uio_in, ui_in, rst_n, clk}
    localparam int IW_CLK  = 0;
    localparam int IW_RSTN = 1;
    localparam int IW_UI   = 2;
    localparam int IW_UIO  = 10;

    // proj_ow field offsets: {uio_oe, uio_out, uo_out}
    localparam int OW_UO      = 0;
    localparam int OW_UIO_OUT = 8;
    localparam int OW_UIO_OE  = 16;

    // Reset-hold counter width
    localparam int RST_CNT_W = 8;

    // State encodings kept as plain constants so older blocks can compare
    // against raw 2-bit values.
    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_DRAIN      = 2'd1;
    localparam logic [1:0] c_ST_ASSERT_RST = 2'd2;
    localparam logic [1:0] c_ST_RUN        = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = c_ST_IDLE,
        ST_DRAIN      = c_ST_DRAIN,
        ST_ASSERT_RST = c_ST_ASSERT_RST,
        ST_RUN        = c_ST_RUN
    } slot_state_t;

    // Build one slot's input word from its individual fields
    function automatic logic [TT_IW_W-1:0] pack_iw(
        input logic [7:0] uio_in,
        input logic [7:0] ui_in,
        input logic       rst_n,
        input logic       clk_b
    );
        logic [TT_IW_W-1:0] w;
        w              = '0;
        w[IW_CLK]      = clk_b;
        w[IW_RSTN]     = rst_n;
        w[IW_UI +: 8]  = ui_in;
        w[IW_UIO +: 8] = uio_in;
        return w;
    endfunction

endpackage : tt_mux_pkg
`default_nettype wire

// File: rtl/tt_mux_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tt_mux_rst_seq
//  Brief   : Reset-hold counter for a newly selected slot. Cleared by
//            i_start, counts while i_count is high, saturates at the last
//            hold cycle and flags it on o_done.
//  Revision: 1.0 - initial release
// ============================================================================
module tt_mux_rst_seq
    import tt_mux_pkg::*;
#(
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_count,
    output logic o_done
);

    localparam logic [RST_CNT_W-1:0] c_LAST = RST_CNT_W'(RST_CYCLES - 1);

    logic [RST_CNT_W-1:0] r_cnt;

    // Hold counter: compared against the last value, never allowed to wrap
    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_cnt <= '0;
        end else if (i_count && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = i_count && (r_cnt == c_LAST);

endmodule : tt_mux_rst_seq
`default_nettype wire

// File: rtl/tt_mux_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tt_mux_slot_ctrl
//  Brief   : Routes the shared TT pad set to one of NUM_PROJ project slots.
//            Switching drains the old slot for one cycle, holds the new
//            slot's rst_n low for RST_CYCLES cycles, then runs it.
//  Revision: 1.0 - initial release
// ============================================================================
module tt_mux_slot_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ   = 4,
    parameter int RST_CYCLES = 4,
    parameter int OUT_REG    = 1,
    localparam int SEL_W     = $clog2(NUM_PROJ + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sel_valid,
    input  logic [SEL_W-1:0]            sel_id,
    output logic                        sel_ready,
    input  logic                        pad_clk,
    input  logic                        pad_rst_n,
    input  logic [7:0]                  pad_ui_in,
    input  logic [7:0]                  pad_uio_in,
    output logic [7:0]                  pad_uo_out,
    output logic [7:0]                  pad_uio_out,
    output logic [7:0]                  pad_uio_oe,
    output logic [NUM_PROJ-1:0]         proj_ena,
    output logic [NUM_PROJ*TT_IW_W-1:0] proj_iw,
    input  logic [NUM_PROJ*TT_OW_W-1:0] proj_ow,
    output logic [SEL_W-1:0]            active_id,
    output logic                        busy
);

    localparam logic [SEL_W-1:0] c_NONE = SEL_W'(NUM_PROJ);

    slot_state_t        r_state;
    slot_state_t        w_state_nxt;
    logic [SEL_W-1:0]   r_active_id;
    logic [SEL_W-1:0]   w_active_nxt;
    logic [SEL_W-1:0]   r_target;
    logic [SEL_W-1:0]   w_target_nxt;

    logic               w_accept;
    logic               w_sel_is_slot;
    logic [SEL_W-1:0]   w_sel_clamped;
    logic               w_hold_done;
    logic               w_enter_rst;
    logic               w_slot_live;
    logic               w_rstn_gate;
    logic [TT_OW_W-1:0] w_pad_ow;
    logic [TT_OW_W-1:0] w_pad_q;

    // Reset has priority over any request in the same cycle
    assign sel_ready     = !rst && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept      = sel_valid && sel_ready;
    assign w_sel_is_slot = (sel_id < c_NONE);
    assign w_sel_clamped = w_sel_is_slot ? sel_id : c_NONE;

    // Next-state, owner and pending-target decode
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_id;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_sel_is_slot) begin
                    w_state_nxt  = ST_ASSERT_RST;
                    w_active_nxt = sel_id;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_state_nxt  = ST_DRAIN;
                    w_target_nxt = w_sel_clamped;
                end
            end
            ST_DRAIN: begin
                w_active_nxt = r_target;
                w_state_nxt  = (r_target == c_NONE) ? ST_IDLE : ST_ASSERT_RST;
            end
            ST_ASSERT_RST: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner and target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_active_id <= c_NONE;
            r_target    <= c_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_active_id <= w_active_nxt;
            r_target    <= w_target_nxt;
        end
    end

    assign w_enter_rst = (r_state != ST_ASSERT_RST) && (w_state_nxt == ST_ASSERT_RST);

    tt_mux_rst_seq #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_seq (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_enter_rst),
        .i_count (r_state == ST_ASSERT_RST),
        .o_done  (w_hold_done)
    );

    // Slot gating uses registered state only, so pad_clk forwarding never
    // sees a combinational FSM glitch.
    assign w_slot_live = (r_state == ST_ASSERT_RST) || (r_state == ST_RUN);
    assign w_rstn_gate = (r_state == ST_RUN) && pad_rst_n;

    for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_slot
        logic w_own;
        assign w_own         = w_slot_live && (r_active_id == SEL_W'(gi));
        assign proj_ena[gi]  = w_own;
        assign proj_iw[TT_IW_W*gi +: TT_IW_W] =
            w_own ? pack_iw(pad_uio_in, pad_ui_in, w_rstn_gate, pad_clk) : '0;
    end

    // Return-path select: only the running slot reaches the pads
    always_comb begin
        w_pad_ow = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if ((r_state == ST_RUN) && (r_active_id == SEL_W'(i))) begin
                w_pad_ow = proj_ow[TT_OW_W*i +: TT_OW_W];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [TT_OW_W-1:0] r_pad_ow;
        // Registered pad outputs, one cycle behind the state
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pad_ow <= '0;
            end else begin
                r_pad_ow <= w_pad_ow;
            end
        end
        assign w_pad_q = r_pad_ow;
    end else begin : g_out_comb
        assign w_pad_q = w_pad_ow;
    end

    assign pad_uo_out  = w_pad_q[OW_UO      +: 8];
    assign pad_uio_out = w_pad_q[OW_UIO_OUT +: 8];
    assign pad_uio_oe  = w_pad_q[OW_UIO_OE  +: 8];
    assign active_id   = r_active_id;
    assign busy        = (r_state == ST_DRAIN) || (r_state == ST_ASSERT_RST);

endmodule : tt_mux_slot_ctrl
`default_nettype wire

// File: tb/tb_tt_mux_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tt_mux_slot_ctrl
//  Brief   : Directed self-checking bench for tt_mux_slot_ctrl with
//            NUM_PROJ=4, RST_CYCLES=4, OUT_REG=1.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_tt_mux_slot_ctrl;

    localparam int NP = 4;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sel_valid = 1'b0;
    logic [SW-1:0]  sel_id = '0;
    logic           sel_ready;
    logic           pad_clk = 1'b1;
    logic           pad_rst_n = 1'b1;
    logic [7:0]     pad_ui_in = 8'h5A;
    logic [7:0]     pad_uio_in = 8'hC3;
    logic [7:0]     pad_uo_out;
    logic [7:0]     pad_uio_out;
    logic [7:0]     pad_uio_oe;
    logic [NP-1:0]  proj_ena;
    logic [NP*18-1:0] proj_iw;
    logic [NP*24-1:0] proj_ow;
    logic [SW-1:0]  active_id;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    int blen;
    logic s2z;

    tt_mux_slot_ctrl #(
        .NUM_PROJ   (NP),
        .RST_CYCLES (4),
        .OUT_REG    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .sel_ready   (sel_ready),
        .pad_clk     (pad_clk),
        .pad_rst_n   (pad_rst_n),
        .pad_ui_in   (pad_ui_in),
        .pad_uio_in  (pad_uio_in),
        .pad_uo_out  (pad_uo_out),
        .pad_uio_out (pad_uio_out),
        .pad_uio_oe  (pad_uio_oe),
        .proj_ena    (proj_ena),
        .proj_iw     (proj_iw),
        .proj_ow     (proj_ow),
        .active_id   (active_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected proj_iw with only `slot` populated from the fixed pad values
    function automatic logic [71:0] exp_iw(input int slot, input logic rstn, input logic clkb);
        logic [71:0] f;
        f = {54'd0, 8'hC3, 8'h5A, rstn, clkb};
        return f << (18 * slot);
    endfunction

    function automatic logic [23:0] pads();
        return {pad_uio_oe, pad_uio_out, pad_uo_out};
    endfunction

    initial begin
        // slot3 .. slot0
        proj_ow = {24'h0FF055, 24'hA53C0F, 24'h112233, 24'h776644};

        // Request coincident with reset must be ignored
        rst = 1'b1; sel_valid = 1'b1; sel_id = 3'd2;
        tick();
        check("rst_sel_ready", sel_ready, 0);
        tick();
        rst = 1'b0; sel_valid = 1'b0;
        #1;
        check("rst_ena", proj_ena, 0);
        check("rst_iw", proj_iw, 0);
        check("rst_pads", pads(), 0);
        check("rst_active", active_id, 4);
        check("rst_busy", busy, 0);
        check("idle_ready", sel_ready, 1);

        // IDLE -> slot 2 with reset hold
        sel_valid = 1'b1; sel_id = 3'd2;
        tick();
        sel_valid = 1'b0;
        check("sel2_ena", proj_ena, 4'b0100);
        check("sel2_active", active_id, 2);
        check("sel2_iw", proj_iw, exp_iw(2, 1'b0, 1'b1));
        check("sel2_ready", sel_ready, 0);
        for (int k = 0; k < 4; k++) begin
            check("hold2_rstn", proj_iw[37], 0);
            check("hold2_busy", busy, 1);
            tick();
        end
        check("run2_busy", busy, 0);
        check("run2_iw", proj_iw, exp_iw(2, 1'b1, 1'b1));
        check("run2_pads_lag", pads(), 0);
        check("run2_ready", sel_ready, 1);
        tick();
        check("run2_pads", pads(), 24'hA53C0F);
        pad_clk = 1'b0;
        #1;
        check("run2_clk_fwd", proj_iw, exp_iw(2, 1'b1, 1'b0));
        pad_clk = 1'b1; pad_rst_n = 1'b0;
        #1;
        check("run2_rstn_fwd", proj_iw, exp_iw(2, 1'b0, 1'b1));
        pad_rst_n = 1'b1;

        // Switch 2 -> 1
        sel_valid = 1'b1; sel_id = 3'd1;
        tick();
        sel_valid = 1'b0;
        check("drain_ena", proj_ena, 0);
        check("drain_iw", proj_iw, 0);
        check("drain_active", active_id, 2);
        check("drain_busy", busy, 1);
        check("drain_pads_lag", pads(), 24'hA53C0F);
        tick();
        check("sw1_ena", proj_ena, 4'b0010);
        check("sw1_active", active_id, 1);
        check("sw1_pads", pads(), 0);
        check("sw1_iw", proj_iw, exp_iw(1, 1'b0, 1'b1));
        blen = 2;
        s2z  = (proj_iw[36 +: 18] == 18'd0);
        for (int k = 0; k < 20 && busy; k++) begin
            tick();
            if (busy) blen++;
            if (proj_iw[36 +: 18] != 18'd0) s2z = 1'b0;
        end
        check("sw1_busy_len", blen, 5);
        check("sw1_slot2_zero", s2z, 1);
        check("run1_ena", proj_ena, 4'b0010);
        check("run1_iw", proj_iw, exp_iw(1, 1'b1, 1'b1));
        tick();
        check("run1_pads", pads(), 24'h112233);

        // Same-id reselect re-resets; next request is held through the hold
        sel_valid = 1'b1; sel_id = 3'd1;
        #1;
        check("rsel_ready", sel_ready, 1);
        tick();
        sel_id = 3'd3;
        #1;
        check("rsel_drain_busy", busy, 1);
        check("rsel_drain_ena", proj_ena, 0);
        check("rsel_drain_ready", sel_ready, 0);
        tick();
        check("rsel_ena", proj_ena, 4'b0010);
        check("rsel_iw", proj_iw, exp_iw(1, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            check("held_ready", sel_ready, 0);
            tick();
        end
        check("held_last_busy", busy, 1);
        tick();
        check("held_run_ena", proj_ena, 4'b0010);
        check("held_run_ready", sel_ready, 1);
        check("held_run_busy", busy, 0);
        tick();
        sel_valid = 1'b0;
        check("held_acc_busy", busy, 1);
        check("held_acc_active", active_id, 1);
        check("held_acc_ena", proj_ena, 0);
        tick();
        check("sel3_ena", proj_ena, 4'b1000);
        check("sel3_active", active_id, 3);
        for (int k = 0; k < 4; k++) tick();
        check("run3_ena", proj_ena, 4'b1000);
        check("run3_busy", busy, 0);
        tick();
        check("run3_pads", pads(), 24'h0FF055);

        // Deselect from RUN
        sel_valid = 1'b1; sel_id = 3'd4;
        tick();
        sel_valid = 1'b0;
        check("desel_drain_busy", busy, 1);
        check("desel_drain_ena", proj_ena, 0);
        check("desel_drain_pads", pads(), 24'h0FF055);
        tick();
        check("desel_active", active_id, 4);
        check("desel_busy", busy, 0);
        check("desel_ena", proj_ena, 0);
        check("desel_iw", proj_iw, 0);
        check("desel_pads", pads(), 0);

        // Deselect while already idle (out-of-range id)
        sel_valid = 1'b1; sel_id = 3'd6;
        #1;
        check("idle_desel_ready", sel_ready, 1);
        tick();
        sel_valid = 1'b0;
        check("idle_desel_active", active_id, 4);
        check("idle_desel_busy", busy, 0);
        check("idle_desel_ena", proj_ena, 0);

        // Reset in the middle of the hold
        sel_valid = 1'b1; sel_id = 3'd0;
        tick();
        sel_valid = 1'b0;
        check("sel0_ena", proj_ena, 4'b0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_ena", proj_ena, 0);
        check("midrst_iw", proj_iw, 0);
        check("midrst_pads", pads(), 0);
        check("midrst_active", active_id, 4);
        check("midrst_busy", busy, 0);

        // Fresh hold after reset is full length
        sel_valid = 1'b1; sel_id = 3'd0;
        tick();
        sel_valid = 1'b0;
        blen = 1;
        for (int k = 0; k < 20 && busy; k++) begin
            tick();
            if (busy) blen++;
        end
        check("sel0_hold_len", blen, 4);
        check("run0_iw", proj_iw, exp_iw(0, 1'b1, 1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tt_mux_slot_ctrl
`default_nettype wire
